// File: rtl/lock_core_param_if.sv
// Button inputs and status outputs of the parametrised combination lock core.
// The chip top (or a bench) drives the master side; the lock core is the slave.
interface lock_core_param_if #(
    parameter int DIGIT_W   = 4,
    parameter int CODE_LEN  = 4,
    parameter int MAX_FAILS = 3
);
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    // User inputs: level signals, the core does its own edge detection
    logic [DIGIT_W-1:0] in_digit;
    logic               enter_btn;
    logic               relock_btn;
    logic               prog_btn;

    // Status outputs, all registered inside the core
    logic               locked_led;
    logic               unlocked_led;
    logic               error_led;
    logic               lockout_led;
    logic [2:0]         state_leds;
    logic [CNT_W-1:0]   digit_count;
    logic [FAIL_W-1:0]  fail_count;

    modport master (
        output in_digit, enter_btn, relock_btn, prog_btn,
        input  locked_led, unlocked_led, error_led, lockout_led,
               state_leds, digit_count, fail_count
    );

    modport slave (
        input  in_digit, enter_btn, relock_btn, prog_btn,
        output locked_led, unlocked_led, error_led, lockout_led,
               state_leds, digit_count, fail_count
    );
endinterface

// File: rtl/lock_core_param.sv
// Parametrised combination lock core: configurable digit width and code
// length, user-programmable code, failed-attempt counter with timed lockout
// and auto-relock after a period in UNLOCKED.
module lock_core_param #(
    parameter int                           DIGIT_W        = 4,
    parameter int                           CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE   = 16'h4321,
    parameter int                           MAX_FAILS      = 3,
    parameter int                           ERR_CYCLES     = 4,
    parameter int                           LOCKOUT_CYCLES = 1000,
    parameter int                           UNLOCK_CYCLES  = 500
) (
    input  logic              clk,
    input  logic              reset,
    lock_core_param_if.slave  bus
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    // Shared timer is sized for the longest of the three timeouts
    localparam int MAX_T_A = (ERR_CYCLES > LOCKOUT_CYCLES) ? ERR_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_T   = (MAX_T_A > UNLOCK_CYCLES) ? MAX_T_A : UNLOCK_CYCLES;
    localparam int TMR_W   = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  ERR_LAST  = TMR_W'(ERR_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LKO_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  UNL_LAST  = TMR_W'((UNLOCK_CYCLES == 0) ? 0 : UNLOCK_CYCLES - 1);
    localparam bit                UNLOCK_EN = (UNLOCK_CYCLES != 0);

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_ENTRY    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_ERROR    = 3'd3,
        S_LOCKOUT  = 3'd4,
        S_PROGRAM  = 3'd5
    } state_t;

    typedef struct packed {
        logic       locked;
        logic       unlocked;
        logic       error;
        logic       lockout;
        logic [2:0] code;
    } leds_t;

    // LED pattern for a state; written together with the state so the
    // LED outputs are registered and never lag the state register.
    function automatic leds_t leds_of(input state_t s);
        leds_t l;
        l.locked   = (s == S_LOCKED) || (s == S_ENTRY);
        l.unlocked = (s == S_UNLOCKED);
        l.error    = (s == S_ERROR) || (s == S_LOCKOUT);
        l.lockout  = (s == S_LOCKOUT);
        l.code     = s;
        return l;
    endfunction

    state_t             state;
    leds_t              leds;
    logic [CODE_W-1:0]  code_q;
    logic [CODE_W-1:0]  shadow_q;
    logic [CODE_W-1:0]  shadow_commit;
    logic [CNT_W-1:0]   digit_count;
    logic               mismatch;
    logic [FAIL_W-1:0]  fail_count;
    logic [FAIL_W-1:0]  fail_next;
    logic [TMR_W-1:0]   timer;
    logic               enter_prev;
    logic               relock_prev;
    logic               prog_prev;
    logic               enter_rise;
    logic               relock_rise;
    logic               prog_rise;
    logic [DIGIT_W-1:0] cur_digit;
    logic               attempt_mismatch;
    logic               last_digit;

    assign enter_rise  = bus.enter_btn  & ~enter_prev;
    assign relock_rise = bus.relock_btn & ~relock_prev;
    assign prog_rise   = bus.prog_btn   & ~prog_prev;

    // Previous-value registers for button edge detection
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values; combinational blocks below use blocking (=).
        if (reset) begin
            enter_prev  <= 1'b0;
            relock_prev <= 1'b0;
            prog_prev   <= 1'b0;
        end else begin
            enter_prev  <= bus.enter_btn;
            relock_prev <= bus.relock_btn;
            prog_prev   <= bus.prog_btn;
        end
    end

    // Select the stored code digit that the next entered digit is compared with
    always_comb begin
        // NOTE: default assignment first so no path leaves cur_digit unassigned
        // (which would infer a latch).
        cur_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_count == CNT_W'(i)) begin
                cur_digit = code_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // Full new code as it will be committed on the last programming digit
    always_comb begin
        shadow_commit = shadow_q;
        shadow_commit[(CODE_LEN-1)*DIGIT_W +: DIGIT_W] = bus.in_digit;
    end

    // In LOCKED, digit_count and mismatch are already 0, so the same
    // expressions serve the first digit and every later one.
    assign attempt_mismatch = mismatch | (bus.in_digit != cur_digit);
    assign last_digit       = (digit_count == CNT_LAST);
    assign fail_next        = fail_count + FAIL_W'(1);

    // Shadow code register collecting digits during programming
    always_ff @(posedge clk) begin
        // NOTE: no reset here -- the shadow is only read after every digit has
        // been rewritten in the current programming pass.
        if (state == S_PROGRAM && enter_rise && !relock_rise) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                if (digit_count == CNT_W'(i)) begin
                    shadow_q[i*DIGIT_W +: DIGIT_W] <= bus.in_digit;
                end
            end
        end
    end

    // Lock state machine with counters, timer, code register and LED outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_LOCKED;
            leds        <= leds_of(S_LOCKED);
            code_q      <= DEFAULT_CODE;
            digit_count <= '0;
            mismatch    <= 1'b0;
            fail_count  <= '0;
            timer       <= '0;
        end else begin
            case (state)
                S_LOCKED, S_ENTRY: begin
                    if (state == S_ENTRY && relock_rise) begin
                        state       <= S_LOCKED;
                        leds        <= leds_of(S_LOCKED);
                        digit_count <= '0;
                        mismatch    <= 1'b0;
                    end else if (enter_rise) begin
                        if (last_digit) begin
                            digit_count <= '0;
                            mismatch    <= 1'b0;
                            timer       <= '0;
                            if (!attempt_mismatch) begin
                                state      <= S_UNLOCKED;
                                leds       <= leds_of(S_UNLOCKED);
                                fail_count <= '0;
                            end else if (fail_next < FAIL_MAX) begin
                                state      <= S_ERROR;
                                leds       <= leds_of(S_ERROR);
                                fail_count <= fail_next;
                            end else begin
                                state      <= S_LOCKOUT;
                                leds       <= leds_of(S_LOCKOUT);
                                fail_count <= FAIL_MAX;
                            end
                        end else begin
                            state       <= S_ENTRY;
                            leds        <= leds_of(S_ENTRY);
                            digit_count <= digit_count + CNT_W'(1);
                            mismatch    <= attempt_mismatch;
                        end
                    end
                end

                S_ERROR: begin
                    if (timer == ERR_LAST) begin
                        state <= S_LOCKED;
                        leds  <= leds_of(S_LOCKED);
                        timer <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                S_LOCKOUT: begin
                    if (timer == LKO_LAST) begin
                        state      <= S_LOCKED;
                        leds       <= leds_of(S_LOCKED);
                        fail_count <= '0;
                        timer      <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                S_UNLOCKED: begin
                    if (relock_rise) begin
                        state <= S_LOCKED;
                        leds  <= leds_of(S_LOCKED);
                        timer <= '0;
                    end else if (prog_rise) begin
                        state       <= S_PROGRAM;
                        leds        <= leds_of(S_PROGRAM);
                        digit_count <= '0;
                        timer       <= '0;
                    end else if (UNLOCK_EN && timer == UNL_LAST) begin
                        state <= S_LOCKED;
                        leds  <= leds_of(S_LOCKED);
                        timer <= '0;
                    end else if (UNLOCK_EN) begin
                        // Timer only runs when auto-relock is enabled, so it never wraps
                        timer <= timer + TMR_W'(1);
                    end
                end

                S_PROGRAM: begin
                    if (relock_rise) begin
                        state       <= S_LOCKED;
                        leds        <= leds_of(S_LOCKED);
                        digit_count <= '0;
                    end else if (enter_rise) begin
                        if (last_digit) begin
                            code_q      <= shadow_commit;
                            state       <= S_LOCKED;
                            leds        <= leds_of(S_LOCKED);
                            digit_count <= '0;
                        end else begin
                            digit_count <= digit_count + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state       <= S_LOCKED;
                    leds        <= leds_of(S_LOCKED);
                    digit_count <= '0;
                    mismatch    <= 1'b0;
                    timer       <= '0;
                end
            endcase
        end
    end

    assign bus.locked_led   = leds.locked;
    assign bus.unlocked_led = leds.unlocked;
    assign bus.error_led    = leds.error;
    assign bus.lockout_led  = leds.lockout;
    assign bus.state_leds   = leds.code;
    assign bus.digit_count  = digit_count;
    assign bus.fail_count   = fail_count;

endmodule

// File: doc/lock_core_param.md
Name: lock_core_param

Overview:
- Parametrised digital combination lock core, successor to the fixed 4-digit lock core.
- Adds configurable digit width and code length, a user-programmable code, a failed-attempt counter with timed lockout, and auto-relock.
- Sits under the chip top; the top maps the user inputs and LED outputs to pins.

Parameters:
DIGIT_W, 4, bits per entered digit
CODE_LEN, 4, digits per code (≥1)
DEFAULT_CODE, 16'h4321, reset code, CODE_LEN*DIGIT_W bits; digit i = bits [i*DIGIT_W +: DIGIT_W]; digit 0 is entered first (default sequence 1,2,3,4)
MAX_FAILS, 3, consecutive wrong codes that trigger lockout (≥1)
ERR_CYCLES, 4, clk cycles the ERROR state is held (≥1)
LOCKOUT_CYCLES, 1000, clk cycles the LOCKOUT state is held (≥1)
UNLOCK_CYCLES, 500, auto-relock timeout in UNLOCKED; 0 disables it

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
in_digit  in  DIGIT_W  digit value, sampled on an enter_btn rising edge
enter_btn  in  1  level input; each rising edge enters one digit
relock_btn  in  1  level input; rising edge forces relock or abort
prog_btn  in  1  level input; rising edge in UNLOCKED starts code programming
locked_led  out  1  high in LOCKED or ENTRY
unlocked_led  out  1  high in UNLOCKED
error_led  out  1  high in ERROR or LOCKOUT
lockout_led  out  1  high in LOCKOUT
state_leds  out  3  encoded state
digit_count  out  $clog2(CODE_LEN+1)  digits entered in the current sequence
fail_count  out  $clog2(MAX_FAILS+1)  consecutive failed attempts

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. All state, counters and outputs are registered on the rising edge of `clk`.
- Edge detect: each button has a previous-value register, reset to 0. A rising edge is button=1 while prev=0, detected in a cycle; its effect is visible on the outputs one clk later. A held button counts once.
- States and state_leds encoding: LOCKED=0, ENTRY=1, UNLOCKED=2, ERROR=3, LOCKOUT=4, PROGRAM=5.
- On reset:
  - state=LOCKED; code register=DEFAULT_CODE.
  - digit_count=0, fail_count=0, mismatch flag=0, timers=0.
  - locked_led=1; all other LEDs 0.
  - Reset mid-operation aborts any entry or programming. The code register also returns to DEFAULT_CODE.
- LOCKED:
  - An enter edge compares in_digit with code digit 0. The mismatch flag is set if they differ. digit_count=1.
  - Go to ENTRY; if CODE_LEN==1, evaluate immediately instead (see ENTRY).
- ENTRY:
  - Each enter edge compares in_digit with code digit[digit_count], ORs the result into the mismatch flag, and increments digit_count.
  - When the digit just entered is the last one (digit_count reaches CODE_LEN), the attempt is evaluated in that same transition:
    - No mismatch: go to UNLOCKED; fail_count=0.
    - Mismatch and fail_count+1 < MAX_FAILS: fail_count++, go to ERROR.
    - Mismatch and fail_count+1 == MAX_FAILS: fail_count=MAX_FAILS, go to LOCKOUT.
  - digit_count and the mismatch flag clear on leaving ENTRY.
  - A relock edge in ENTRY abandons the attempt and returns to LOCKED. fail_count is unchanged. relock has priority over a simultaneous enter.
- ERROR: hold for ERR_CYCLES cycles, then go to LOCKED. All buttons are ignored.
- LOCKOUT: hold for LOCKOUT_CYCLES cycles, then go to LOCKED with fail_count=0. All buttons are ignored.
- UNLOCKED:
  - The timer counts from 0. When it reaches UNLOCK_CYCLES-1 (UNLOCK_CYCLES≠0), go to LOCKED.
  - A relock edge goes to LOCKED.
  - A prog edge goes to PROGRAM.
  - Priority: relock > prog > timeout.
  - Enter edges are ignored.
- PROGRAM:
  - Each enter edge writes in_digit into shadow digit[digit_count] and increments digit_count.
  - On the CODE_LEN-th digit, the shadow is committed to the code register atomically and the block goes to LOCKED.
  - A relock edge aborts: the code is unchanged, go to LOCKED. relock has priority over a simultaneous enter.
  - locked_led=0, unlocked_led=0 in PROGRAM.
- Counter widths: timers are sized by $clog2 of the largest timeout parameter and never wrap. fail_count saturates at MAX_FAILS.

Test Plan:
- Defaults: reset, then enter 1,2,3,4 → unlocked_led=1 and state_leds=2 one clk after the 4th edge; fail_count=0.
- Wrong code: enter 1,2,3,5 → ERROR (state_leds=3, error_led=1) for 4 cycles, then LOCKED, fail_count=1. Hold enter_btn high for 10 cycles → counts as 1 digit.
- Lockout: enter 3 wrong codes → after the 3rd, LOCKOUT with lockout_led=1 for 1000 cycles; enter edges in this window are ignored; then LOCKED with fail_count=0.
- Reprogram: unlock, prog edge, enter 9,8,7,6 → LOCKED. Then 1,2,3,4 fails; 9,8,7,6 unlocks. Reset → 1,2,3,4 unlocks again.
- Abort paths: relock mid-PROGRAM after 2 digits → code unchanged. relock mid-ENTRY → LOCKED with fail_count unchanged. Simultaneous relock+enter in ENTRY → LOCKED.
- Auto-relock and reset: unlock with UNLOCK_CYCLES=500, idle → LOCKED after 500 cycles. Assert reset during ERROR → LOCKED next cycle with all counters 0.
